// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling,
// single-entry valid/ready output register with frame-error and overrun pulses.
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int OSW = $clog2(OS_RATE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OS_RATE - 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OS_RATE / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic                 rx_meta_q;
  logic                 rx_sync_q;
  logic                 rx_q;
  logic                 rx_s;
  state_t               state_q,     state_d;
  logic [OSW-1:0]       os_cnt_q,    os_cnt_d;
  logic [BCW-1:0]       bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 take_s;

  assign rx_s      = rx_sync_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Synchronizer resets to the idle level so reset release never fakes a start edge.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_q      <= rx_sync_q;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      os_cnt_q    <= {OSW{1'b0}};
      bit_cnt_q   <= {BCW{1'b0}};
      shift_q     <= {DATA_BITS{1'b0}};
      rx_data_q   <= {DATA_BITS{1'b0}};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    take_s      = rx_valid_q & rx_ready;

    if (take_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_q && !rx_s) begin
          state_d  = START;
          os_cnt_d = {OSW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        if (baud_tick && (os_cnt_q == OS_MID)) begin
          os_cnt_d = {OSW{1'b0}};
          // A start bit that is high again at its midpoint was a glitch.
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = {BCW{1'b0}};
          end else begin
            state_d   = IDLE;
          end
        end else if (baud_tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end
      DATA: begin
        if (baud_tick && (os_cnt_q == OS_LAST)) begin
          shift_d[bit_cnt_q] = rx_s;
          os_cnt_d           = {OSW{1'b0}};
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = {BCW{1'b0}};
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (baud_tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end
      STOP: begin
        if (baud_tick && (os_cnt_q == OS_LAST)) begin
          state_d  = IDLE;
          os_cnt_d = {OSW{1'b0}};
          // Load is allowed when the slot is empty or being drained this very cycle.
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_q || take_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d  = 1'b1;
          end
        end else if (baud_tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end
      default: begin
        state_d  = IDLE;
        os_cnt_d = {OSW{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: serial frames built from a bit list, expected deliveries and
// flags queued by a frame-level model, and an independent output monitor that pops them.
module tb_uart_rx_os16;

  localparam int DB  = 8;
  localparam int OS  = 16;
  localparam int DIV = 2;
  localparam int EV_DATA = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OV   = 2;
  localparam int MID_STOP_TICK = OS / 2 + OS * DB + OS;

  typedef struct {
    int            kind;
    logic [DB-1:0] data;
  } ev_t;

  logic          Clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;

  ev_t           exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            div_cnt = 0;
  bit            model_full = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DB-1:0] prev_data = '0;

  uart_rx_os16 #(.DATA_BITS(DB), .OS_RATE(OS)) dut (
    .Clk       (Clk),
    .Resetn    (Resetn),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [DB-1:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [DB-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: actual kind=%0d data=%0h expected no event", kind, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == EV_DATA) check("event_data", d, e.data);
    end
  endtask

  // Frame-level model: one event per completed frame, from the stop bit and slot occupancy.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop, input bit rdy);
    if (rdy) model_full = 1'b0;
    if (!stop) push_ev(EV_FE, '0);
    else if (model_full) push_ev(EV_OV, '0);
    else begin
      push_ev(EV_DATA, d);
      model_full = 1'b1;
    end
  endtask

  task automatic clk_step();
    @(negedge Clk);
    div_cnt  = (div_cnt + 1) % DIV;
    baud_tick = (div_cnt == DIV - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      clk_step();
      rx = 1'b1;
    end
  endtask

  // The receiver sees the edge 3 clocks after rx falls and counts ticks from then on;
  // each line bit is held for OS counted ticks.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input bit rdy, input int abort_at);
    logic [DB+1:0] bits;
    int t, k, b;
    bit counted;
    bits = {stop, d, 1'b0};
    if (abort_at == 0) model_frame(d, stop, rdy);
    t = 0;
    k = 0;
    while (t < OS * (DB + 2)) begin
      clk_step();
      k++;
      b        = t / OS;
      rx       = bits[b];
      counted  = (k >= 4) && baud_tick;
      rx_ready = rdy && counted && (t + 1 == MID_STOP_TICK);
      if (counted) t++;
      if (abort_at != 0 && t == abort_at) break;
    end
    clk_step();
    rx       = 1'b1;
    rx_ready = 1'b0;
  endtask

  task automatic glitch(input int low_ticks);
    int t, k;
    clk_step();
    rx = 1'b0;
    t = 0;
    k = 1;
    while (t < low_ticks) begin
      clk_step();
      k++;
      if (k >= 4 && baud_tick) t++;
    end
    clk_step();
    rx = 1'b1;
  endtask

  task automatic consume();
    check("valid_before_take", rx_valid, 1'b1);
    clk_step();
    rx_ready = 1'b1;
    clk_step();
    rx_ready = 1'b0;
    model_full = 1'b0;
  endtask

  // Monitor: samples 1 ns after each rising edge; rx_ready then still holds the value that edge saw.
  always @(posedge Clk) begin
    #1;
    if (!Resetn) begin
      prev_valid = 1'b0;
    end else begin
      if (frame_err) expect_ev(EV_FE, '0);
      if (overrun) expect_ev(EV_OV, '0);
      if (rx_valid && (!prev_valid || rx_ready)) expect_ev(EV_DATA, rx_data);
      if (prev_valid && !rx_ready) begin
        check("hold_valid", rx_valid, 1'b1);
        check("hold_data", rx_data, prev_data);
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  initial begin
    logic [DB-1:0] d;
    logic          stop;
    bit            rdy;

    repeat (4) clk_step();
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    Resetn = 1'b1;
    idle(10);

    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(5);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1'b1);
    consume();
    idle(5);

    send_frame(8'h3C, 1'b1, 1'b0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    idle(5);
    check("overrun_keeps_data", rx_data, 8'h3C);
    consume();
    idle(5);

    send_frame(8'h55, 1'b0, 1'b0, 0);
    idle(5);
    check("ferr_no_valid", rx_valid, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, 0);
    idle(5);
    check("after_ferr_data", rx_data, 8'h12);
    consume();
    idle(5);

    glitch(4);
    idle(40);
    check("glitch_no_valid", rx_valid, 1'b0);
    check("glitch_no_events", exp_q.size(), 0);

    send_frame(8'h01, 1'b1, 1'b0, 0);
    send_frame(8'h02, 1'b1, 1'b1, 0);
    idle(5);
    check("same_cycle_data", rx_data, 8'h02);
    check("same_cycle_valid", rx_valid, 1'b1);
    consume();
    idle(5);

    send_frame(8'h5A, 1'b1, 1'b0, OS / 2 + OS * 4);
    rx     = 1'b1;
    Resetn = 1'b0;
    repeat (3) clk_step();
    check("midframe_reset_valid", rx_valid, 1'b0);
    check("midframe_reset_data", rx_data, 8'h00);
    Resetn = 1'b1;
    model_full = 1'b0;
    idle(10);
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    idle(5);
    check("after_reset_data", rx_data, 8'h7E);
    consume();

    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      if (model_full && $urandom_range(0, 1) == 1) consume();
      rdy  = model_full && ($urandom_range(0, 2) == 0);
      idle($urandom_range(0, 20));
      send_frame(d, stop, rdy, 0);
    end

    idle(40);
    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
